// File: rtl/hazard_unit.sv
// Hazard control for the pipelined RV32I core: forwarding, load-use and branch
// handling, a data-memory wait FSM with timeout, and stall/flush counters.
module hazard_unit #(
  parameter int unsigned REGISTER_ADDRESS_WIDTH = 5,
  parameter int unsigned CNT_WIDTH              = 32,
  parameter int unsigned MEM_TIMEOUT            = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE,
  input  logic [1:0]                        ResultSrcE,
  input  logic                              PCSrcE,
  input  logic                              RegWriteM,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM,
  input  logic                              RegWriteW,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW,
  input  logic                              MemReqM,
  input  logic                              MemReadyM,
  output logic                              StallF,
  output logic                              StallD,
  output logic                              StallE,
  output logic                              StallM,
  output logic                              FlushD,
  output logic                              FlushE,
  output logic [1:0]                        ForwardAE,
  output logic [1:0]                        ForwardBE,
  output logic                              MemErr,
  output logic [CNT_WIDTH-1:0]              StallCount,
  output logic [CNT_WIDTH-1:0]              FlushCount
);

  localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT);
  localparam logic [REGISTER_ADDRESS_WIDTH-1:0] ZERO_REG = '0;

  typedef enum logic {
    S_RUN,
    S_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [WCNT_W-1:0]   wait_q, wait_d;
  logic                mem_err_q, mem_err_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

  logic timeout;
  logic mem_wait;
  logic lw_stall;

  assign timeout  = (state_q == S_WAIT) && (wait_q == WCNT_W'(MEM_TIMEOUT - 1));
  assign mem_wait = ((state_q == S_RUN)  && MemReqM && !MemReadyM) ||
                    ((state_q == S_WAIT) && !MemReadyM && !timeout);
  assign lw_stall = (ResultSrcE == 2'b01) && (RdE != ZERO_REG) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  // Memory-wait FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RUN;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Next-state: a timeout releases the stall and latches a sticky error
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_err_d = mem_err_q;
    case (state_q)
      S_RUN: begin
        if (MemReqM && !MemReadyM) begin
          state_d = S_WAIT;
          wait_d  = '0;
        end
      end
      S_WAIT: begin
        if (MemReadyM) begin
          state_d = S_RUN;
        end else if (timeout) begin
          state_d   = S_RUN;
          mem_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WCNT_W'(1);
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Stall/flush/forward selection; memory wait outranks branch, branch outranks load-use
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      if (RegWriteM && (RdM == Rs1E) && (Rs1E != ZERO_REG))      ForwardAE = 2'b10;
      else if (RegWriteW && (RdW == Rs1E) && (Rs1E != ZERO_REG)) ForwardAE = 2'b01;
      if (RegWriteM && (RdM == Rs2E) && (Rs2E != ZERO_REG))      ForwardBE = 2'b10;
      else if (RegWriteW && (RdW == Rs2E) && (Rs2E != ZERO_REG)) ForwardBE = 2'b01;

      if (mem_wait) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallF && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      if (PCSrcE && FlushE && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign MemErr     = mem_err_q;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: combinational vector table plus
// hand-written memory-wait, timeout, saturation and reset sequences.
module tb_hazard_unit;

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]    ResultSrcE;
  logic          PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, MemErr;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [CW-1:0] StallCount, FlushCount;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_unit #(
    .REGISTER_ADDRESS_WIDTH(AW),
    .CNT_WIDTH(CW),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .RdM(RdM), .RegWriteW(RegWriteW), .RdW(RdW),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemErr(MemErr), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  // exp packs {StallF,StallD,StallE,StallM,FlushD,FlushE,ForwardAE,ForwardBE}
  typedef struct {
    logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde;
    logic [1:0]    rsrc;
    logic          pcsrc, rwm;
    logic [AW-1:0] rdm;
    logic          rww;
    logic [AW-1:0] rdw;
    logic          req, rdy;
    logic [9:0]    exp;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [9:0] ctl();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e; RdE = v.rde;
    ResultSrcE = v.rsrc; PCSrcE = v.pcsrc; RegWriteM = v.rwm; RdM = v.rdm;
    RegWriteW = v.rww; RdW = v.rdw; MemReqM = v.req; MemReadyM = v.rdy;
  endtask

  task automatic idle();
    vec_t z;
    z = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 10'd0};
    apply(z);
  endtask

  // Advance one clock; leave time 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        rs1d  rs2d  rs1e  rs2e  rde   rsrc  pc    rwm   rdm   rww   rdw   req   rdy   exp
    vecs[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 10'b000000_00_00};
    vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 10'b000000_10_00};
    vecs[2]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 10'b000000_01_00};
    vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 10'b000000_00_00};
    vecs[4]  = '{5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 2'b00, 1'b0, 1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 10'b000000_00_10};
    vecs[5]  = '{5'd0, 5'd0, 5'd3, 5'd4, 5'd0, 2'b00, 1'b0, 1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 1'b0, 10'b000000_10_01};
    vecs[6]  = '{5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 5'd5, 1'b0, 5'd6, 1'b0, 1'b0, 10'b000000_00_00};
    vecs[7]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 2'b01, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 10'b110001_00_00};
    vecs[8]  = '{5'd7, 5'd2, 5'd0, 5'd0, 5'd7, 2'b01, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 10'b110001_00_00};
    vecs[9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 10'b000000_00_00};
    vecs[10] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 2'b10, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 10'b000000_00_00};
    vecs[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 10'b000011_00_00};
    vecs[12] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 2'b01, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 10'b000011_00_00};
    vecs[13] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 10'b000000_00_00};

    // Reset: forwarding inputs active but outputs must stay forced
    rst = 1'b1;
    apply(vecs[1]);
    step();
    step();
    chk("reset_ctl", 32'(ctl()), 32'(10'b000011_00_00));
    chk("reset_stallcnt", 32'(StallCount), 32'd0);
    chk("reset_flushcnt", 32'(FlushCount), 32'd0);
    chk("reset_memerr", 32'(MemErr), 32'd0);
    rst = 1'b0;

    // Combinational table, one vector per cycle
    for (int i = 0; i < 14; i++) begin
      apply(vecs[i]);
      #2;
      chk($sformatf("vec%0d", i), 32'(ctl()), 32'(vecs[i].exp));
      step();
    end
    chk("table_stallcnt", 32'(StallCount), 32'd2);
    chk("table_flushcnt", 32'(FlushCount), 32'd2);

    // Memory wait of 3 cycles with a pending branch held until release
    idle();
    MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("wait_c%0d", c), 32'(ctl()), 32'(10'b111100_00_00));
      step();
    end
    MemReadyM = 1'b1;
    #2;
    chk("wait_release", 32'(ctl()), 32'(10'b000011_00_00));
    step();
    idle();
    #2;
    chk("wait_back_run", 32'(ctl()), 32'd0);
    chk("wait_memerr", 32'(MemErr), 32'd0);
    chk("wait_stallcnt", 32'(StallCount), 32'd5);
    chk("wait_flushcnt", 32'(FlushCount), 32'd3);
    step();

    // Timeout: 4 stall cycles, released on the 5th, sticky error afterwards
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk($sformatf("to_c%0d", c), 32'(ctl()), 32'(10'b111100_00_00));
      step();
    end
    #2;
    chk("to_release", 32'(ctl()), 32'd0);
    chk("to_err_pre", 32'(MemErr), 32'd0);
    step();
    idle();
    #2;
    chk("to_err_set", 32'(MemErr), 32'd1);
    chk("to_stallcnt", 32'(StallCount), 32'd9);
    step(); step(); step();
    chk("to_err_sticky", 32'(MemErr), 32'd1);

    // Saturation: 18 more stall cycles, ending in WAIT
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int c = 0; c < 22; c++) step();
    chk("sat_stallcnt", 32'(StallCount), 32'd15);
    #2;
    chk("sat_in_wait", 32'(ctl()), 32'(10'b111100_00_00));

    // Reset mid-WAIT
    rst = 1'b1;
    #1;
    chk("rst_wait_ctl", 32'(ctl()), 32'(10'b000011_00_00));
    step();
    rst = 1'b0;
    idle();
    #2;
    chk("post_rst_run", 32'(ctl()), 32'd0);
    chk("post_rst_stallcnt", 32'(StallCount), 32'd0);
    chk("post_rst_flushcnt", 32'(FlushCount), 32'd0);
    chk("post_rst_memerr", 32'(MemErr), 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
